// File: rtl/ones_count_pkg.sv
// Shared definitions for the ones-count controller: default scan width and
// the FSM state encoding.
package ones_count_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ones_count_sreg.sv
// Loadable right-shift register feeding the ones-count FSM.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   i_load         - capture i_data (takes priority over shift)
//   i_shift        - shift right by one, zero fill
//   i_data         - word to capture
//   o_data         - current register contents
//   o_lsb_c        - bit being scanned this cycle
//   o_rem_zero_c   - no 1-bits remain above the LSB
module ones_count_sreg
  import ones_count_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_lsb_c,
  output logic             o_rem_zero_c
);

  logic [WIDTH-1:0] r_sreg;

  // Shift register storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg <= '0;
    end else if (i_load) begin
      r_sreg <= i_data;
    end else if (i_shift) begin
      r_sreg <= r_sreg >> 1;
    end
  end

  assign o_data       = r_sreg;
  assign o_lsb_c      = r_sreg[0];
  assign o_rem_zero_c = (r_sreg[WIDTH-1:1] == '0);

endmodule

// File: rtl/ones_count_ctrl.sv
// Ones-count controller: scans a captured word LSB-first and drives the
// clear/increment strobes of a downstream bit counter, then pulses Done.
// Configuration macro: ONES_COUNT_EARLY_EXIT_EN -- when defined, the scan
// ends as soon as no 1-bits remain in the shift register.
// Ports:
//   clk          - clock, rising edge
//   reset        - asynchronous active-low reset
//   Start        - scan request, accepted only while Ready
//   DataIn       - word to scan, captured on the accepting edge
//   Ready        - idle, Start accepted
//   ClearCounter - one-cycle clear of the downstream counter
//   IncCounter   - one pulse per scanned 1-bit
//   Done         - one-cycle pulse, downstream count valid
module ones_count_ctrl
  import ones_count_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] DataIn,
  output logic             Ready,
  output logic             ClearCounter,
  output logic             IncCounter,
  output logic             Done
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

`ifdef ONES_COUNT_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  state_t           r_state;
  state_t           w_next_state;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_next;
  logic             w_load;
  logic             w_shift;
  logic [WIDTH-1:0] w_sreg;
  logic             w_lsb;
  logic             w_rem_zero;
  logic             w_next_lsb;
  logic             r_ready;
  logic             r_clear;
  logic             r_inc;
  logic             r_done;

  ones_count_sreg #(
    .WIDTH (WIDTH)
  ) u_sreg (
    .clk          (clk),
    .rst_n        (reset),
    .i_load       (w_load),
    .i_shift      (w_shift),
    .i_data       (DataIn),
    .o_data       (w_sreg),
    .o_lsb_c      (w_lsb),
    .o_rem_zero_c (w_rem_zero)
  );

  // State, index and registered output strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_ready <= 1'b1;
      r_clear <= 1'b0;
      r_inc   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_idx_next;
      r_ready <= (w_next_state == ST_IDLE);
      r_clear <= (w_next_state == ST_CLEAR);
      r_inc   <= (w_next_state == ST_SHIFT) && w_next_lsb;
      r_done  <= (w_next_state == ST_DONE);
    end
  end

  // Next-state, shift-register control and next output values
  always_comb begin
    w_next_state = r_state;
    w_idx_next   = r_idx;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (Start) begin
          w_load       = 1'b1;
          w_idx_next   = '0;
          w_next_state = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        w_next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_shift = 1'b1;
        // Index returns to zero on exit so it never wraps past WIDTH-1
        if ((r_idx == IDX_LAST) || (EARLY_EXIT && w_rem_zero)) begin
          w_idx_next   = '0;
          w_next_state = ST_DONE;
        end else begin
          w_idx_next = r_idx + IDX_W'(1);
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
    // Bit that sits in the LSB after this edge (bit 1 when shifting)
    w_next_lsb = w_shift ? (|(w_sreg & WIDTH'(2))) : w_lsb;
  end

  assign Ready        = r_ready;
  assign ClearCounter = r_clear;
  assign IncCounter   = r_inc;
  assign Done         = r_done;

endmodule

// File: tb/tb_ones_count_ctrl.sv
module tb_ones_count_ctrl;

  localparam int W = 8;
`ifdef ONES_COUNT_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         Start = 1'b0;
  logic [W-1:0] DataIn = '0;
  logic         Ready, ClearCounter, IncCounter, Done;

  int checks = 0;
  int errors = 0;
  int dcount = 0;

  ones_count_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .Start        (Start),
    .DataIn       (DataIn),
    .Ready        (Ready),
    .ClearCounter (ClearCounter),
    .IncCounter   (IncCounter),
    .Done         (Done)
  );

  always #5 clk = ~clk;

  // Downstream BitCounter model
  always @(posedge clk) begin
    if (ClearCounter) dcount <= 0;
    else if (IncCounter) dcount <= dcount + 1;
  end

  // Reference model: index of the last SHIFT cycle (0-based)
  function automatic int last_shift(input logic [W-1:0] d);
    int l;
    if (!EE) return W - 1;
    l = 0;
    for (int i = 0; i < W; i++) if (d[i]) l = i;
    return l;
  endfunction

  function automatic int exp_done(input logic [W-1:0] d);
    return 3 + last_shift(d);
  endfunction

  function automatic logic [63:0] exp_inc(input logic [W-1:0] d);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < W; i++) if (d[i]) m[2+i] = 1'b1;
    return m;
  endfunction

  // Drives one scan from a negedge with Ready high and records the outputs
  // by cycle offset from the accepting edge; no checking here.
  task automatic run_scan(input logic [W-1:0] d, output logic [63:0] clr_m,
                          output logic [63:0] inc_m, output int done_at,
                          output int ready_at, output int cnt, output bit overlap);
    int w;
    clr_m = '0; inc_m = '0; done_at = -1; ready_at = -1; cnt = -1; overlap = 0;
    w = 0;
    while (Ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    Start = 1'b1; DataIn = d;
    @(posedge clk);
    for (int j = 1; j < 60; j++) begin
      @(negedge clk);
      if (j == 1) begin Start = 1'b0; DataIn = W'($urandom); end
      if (ClearCounter === 1'b1) clr_m[j] = 1'b1;
      if (IncCounter === 1'b1) inc_m[j] = 1'b1;
      if (ClearCounter === 1'b1 && IncCounter === 1'b1) overlap = 1;
      if (Done === 1'b1 && done_at < 0) begin done_at = j; cnt = dcount; end
      if (done_at >= 0 && j > done_at && Ready === 1'b1) begin ready_at = j; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++;
    if ({Ready, ClearCounter, IncCounter, Done} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 1000", {Ready, ClearCounter, IncCounter, Done});
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({Ready, ClearCounter, IncCounter, Done} !== 4'b1000) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected 1000", {Ready, ClearCounter, IncCounter, Done});
    end
  endtask

  task automatic test_scans();
    logic [W-1:0] pats[$] = '{8'hA5, 8'hFF, 8'h00, 8'h01, 8'h80, 8'h30};
    logic [63:0] clr_m, inc_m;
    int done_at, ready_at, cnt;
    bit ov;
    for (int i = 0; i < 20; i++) pats.push_back(W'($urandom));
    foreach (pats[n]) begin
      run_scan(pats[n], clr_m, inc_m, done_at, ready_at, cnt, ov);
      checks++;
      if (clr_m !== 64'h2) begin
        errors++; $display("FAIL scan_clear d=%h: got %h expected %h", pats[n], clr_m, 64'h2);
      end
      checks++;
      if (inc_m !== exp_inc(pats[n])) begin
        errors++; $display("FAIL scan_inc d=%h: got %h expected %h", pats[n], inc_m, exp_inc(pats[n]));
      end
      checks++;
      if (done_at !== exp_done(pats[n])) begin
        errors++; $display("FAIL scan_done d=%h: got %0d expected %0d", pats[n], done_at, exp_done(pats[n]));
      end
      checks++;
      if (ready_at !== exp_done(pats[n]) + 1) begin
        errors++; $display("FAIL scan_ready d=%h: got %0d expected %0d", pats[n], ready_at, exp_done(pats[n]) + 1);
      end
      checks++;
      if (cnt !== $countones(pats[n])) begin
        errors++; $display("FAIL scan_count d=%h: got %0d expected %0d", pats[n], cnt, $countones(pats[n]));
      end
      checks++;
      if (ov !== 1'b0) begin
        errors++; $display("FAIL scan_overlap d=%h: got %0d expected 0", pats[n], ov);
      end
    end
  endtask

  task automatic test_ignore_start();
    int done_at, n_done, n_clr, cnt, w;
    done_at = -1; n_done = 0; n_clr = 0; cnt = -1; w = 0;
    while (Ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    Start = 1'b1; DataIn = 8'h30;
    @(posedge clk);
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      if (j == 1) begin Start = 1'b0; DataIn = 8'h00; end
      if (j == 4) begin Start = 1'b1; DataIn = 8'h0F; end
      if (j == 5) begin Start = 1'b0; DataIn = 8'h00; end
      if (ClearCounter === 1'b1) n_clr++;
      if (Done === 1'b1) begin n_done++; if (done_at < 0) begin done_at = j; cnt = dcount; end end
    end
    checks++;
    if (cnt !== 2) begin errors++; $display("FAIL ignore_count: got %0d expected 2", cnt); end
    checks++;
    if (done_at !== exp_done(8'h30)) begin
      errors++; $display("FAIL ignore_done: got %0d expected %0d", done_at, exp_done(8'h30));
    end
    checks++;
    if (n_clr !== 1 || n_done !== 1) begin
      errors++; $display("FAIL ignore_extra_scan: got clr=%0d done=%0d expected 1 and 1", n_clr, n_done);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [63:0] clr_m, inc_m;
    int done_at, ready_at, cnt, n_done, w;
    bit ov;
    n_done = 0; w = 0;
    while (Ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    Start = 1'b1; DataIn = 8'hFF;
    @(posedge clk);
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      if (j == 1) Start = 1'b0;
    end
    checks++;
    if (IncCounter !== 1'b1) begin errors++; $display("FAIL mid_scan_active: got %b expected 1", IncCounter); end
    reset = 1'b0;
    #1;
    checks++;
    if ({Ready, ClearCounter, IncCounter, Done} !== 4'b1000) begin
      errors++; $display("FAIL reset_abort_outputs: got %b expected 1000", {Ready, ClearCounter, IncCounter, Done});
    end
    @(negedge clk); reset = 1'b1;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      if (Done === 1'b1 || Ready !== 1'b1) n_done++;
    end
    checks++;
    if (n_done !== 0) begin errors++; $display("FAIL reset_abort_no_done: got %0d expected 0", n_done); end
    run_scan(8'h03, clr_m, inc_m, done_at, ready_at, cnt, ov);
    checks++;
    if (clr_m !== 64'h2 || cnt !== 2) begin
      errors++; $display("FAIL reset_restart: got clr=%h cnt=%0d expected clr=2 cnt=2", clr_m, cnt);
    end
  endtask

  task automatic test_back_to_back();
    int dones[$], clrs[$], cnts[$];
    int w;
    bit found;
    w = 0;
    while (Ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    Start = 1'b1; DataIn = 8'h81;
    @(posedge clk);
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (ClearCounter === 1'b1) clrs.push_back(j);
      if (Done === 1'b1) begin dones.push_back(j); cnts.push_back(dcount); end
    end
    Start = 1'b0;
    checks++;
    if (dones.size() !== 3) begin errors++; $display("FAIL b2b_done_count: got %0d expected 3", dones.size()); end
    foreach (dones[i]) begin
      checks++;
      if (cnts[i] !== 2) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected 2", i, cnts[i]); end
      if (i > 0) begin
        checks++;
        if (dones[i] - dones[i-1] !== W + 3) begin
          errors++; $display("FAIL b2b_period[%0d]: got %0d expected %0d", i, dones[i] - dones[i-1], W + 3);
        end
      end
      found = 0;
      foreach (clrs[c]) if (clrs[c] == dones[i] - (W + 1)) found = 1;
      checks++;
      if (!found) begin errors++; $display("FAIL b2b_clear_before[%0d]: got none expected clear at %0d", i, dones[i] - (W + 1)); end
    end
    w = 0;
    while (Ready !== 1'b1 && w < 30) begin @(negedge clk); w++; end
    checks++;
    if (Ready !== 1'b1) begin errors++; $display("FAIL b2b_return_idle: got %b expected 1", Ready); end
  endtask

  initial begin
    test_reset();
    test_scans();
    test_ignore_start();
    test_reset_mid_scan();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ones_count_ctrl.md
ONES_COUNT_CTRL -- requirements
Module: ones_count_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, width of data word scanned; drives ClearCounter/IncCounter of the downstream 8-bit BitCounter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 Start  input  1  request to scan DataIn; sampled only while Ready=1.
REQ-005 DataIn  input  WIDTH  word whose 1-bits are counted; captured on the accepting edge only.
REQ-006 Ready  output  1  high in IDLE; Start accepted.
REQ-007 ClearCounter  output  1  one-cycle clear pulse to downstream counter.
REQ-008 IncCounter  output  1  one-cycle increment per 1-bit scanned.
REQ-009 Done  output  1  one-cycle pulse; downstream Count valid from this cycle.

Function
REQ-010 FSM states IDLE, CLEAR, SHIFT, DONE; all outputs decoded from registered state/shift register, no input-to-output combinational path.
REQ-011 IDLE: Ready=1; Start=1 at edge -> sreg<=DataIn, idx<=0, next CLEAR; Start=0 -> stay.
REQ-012 CLEAR: ClearCounter=1 for exactly one cycle; next SHIFT.
REQ-013 SHIFT: IncCounter=sreg[0]; each edge sreg<=sreg>>1 (zero fill), idx<=idx+1; exits to DONE after WIDTH cycles (idx==WIDTH-1).
REQ-014 DONE: Done=1 for one cycle; next IDLE unconditionally.
REQ-015 Latency (macro off): Start accepted edge k -> CLEAR cycle k+1, SHIFT k+2..k+WIDTH+1, DONE k+WIDTH+2, Ready again k+WIDTH+3.
REQ-016 Total IncCounter pulses per scan equal popcount(DataIn captured); ClearCounter and IncCounter never high in same cycle.
REQ-017 Start while Ready=0 ignored; DataIn changes after capture have no effect.
REQ-018 Start held high continuously: new scan accepted on first IDLE cycle (back-to-back, one IDLE cycle between scans).
REQ-019 idx is $clog2(WIDTH) bits; no wrap beyond WIDTH-1 reachable.

Reset
REQ-020 reset=0 asynchronously forces state IDLE, sreg=0, idx=0; Ready=1, ClearCounter=0, IncCounter=0, Done=0.
REQ-021 Reset asserted mid-scan aborts scan; no Done issued for aborted scan; next Start after release restarts from CLEAR.

Configuration
REQ-022 Macro ONES_COUNT_EARLY_EXIT_EN defined: SHIFT exits to DONE at end of cycle where sreg[WIDTH-1:1]==0 (no 1-bits remain) or idx==WIDTH-1, whichever first.
REQ-023 Macro undefined: SHIFT always lasts exactly WIDTH cycles; popcount result identical in both builds.

Structure
REQ-024 Package ones_count_pkg holds state encoding constants (IDLE=0, CLEAR=1, SHIFT=2, DONE=3, 2-bit) and default WIDTH.
REQ-025 Sub-module ones_count_sreg: loadable right-shift register (load, shift, data out, LSB, remaining-zero flag); FSM stays in ones_count_ctrl.

Verification
REQ-026 DataIn=8'hA5, Start edge k -> ClearCounter at k+1, IncCounter at k+2,k+4,k+7,k+9 (4 pulses), Done at k+10; downstream Count=4.
REQ-027 DataIn=8'hFF -> 8 consecutive IncCounter cycles, Count=8 at Done; DataIn=8'h00 -> zero pulses, Done at k+10 (macro off) or k+3 (macro on).
REQ-028 DataIn=8'h01 with ONES_COUNT_EARLY_EXIT_EN -> one IncCounter at k+2, Done at k+3, Count=1.
REQ-029 Start pulsed with DataIn=8'h0F during SHIFT of scan 8'h30 -> ignored; Count=2 at Done, no extra scan.
REQ-030 reset=0 at k+5 of 8'hFF scan -> all outputs 0, Ready=1 immediately; release then Start 8'h03 -> Count=2 at Done.
REQ-031 Start held high, DataIn=8'h81 -> repeated scans, each preceded by ClearCounter, Done every WIDTH+3 cycles, Count=2 each time.
